read_dispatcher: RTL and testbench
==================================

READ_DISPATCHER -- requirements
Module: read_dispatcher

Interface
REQ-001 SHALL have parameter num_of_ports, default 16: number of output ports.
REQ-002 SHALL have parameter arbiter_data_width, default 64: SRAM and output word width.
REQ-003 SHALL have parameter des_port_width, default 4: destination port index width.
REQ-004 SHALL have parameter pack_length_width, default 8: packet length in words, header included.
REQ-005 SHALL have parameter addr_width, default 14: SRAM word address width.
REQ-006 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-008 SHALL have port desc_vld  input  1: packet descriptor valid.
REQ-009 SHALL have port desc_des_port  input  des_port_width: destination output port.
REQ-010 SHALL have port desc_pack_length  input  pack_length_width: packet word count.
REQ-011 SHALL have port desc_start_addr  input  addr_width: SRAM address of the first word.
REQ-012 SHALL have port desc_ready  output  1: high only in IDLE; a descriptor is accepted when desc_vld && desc_ready.
REQ-013 SHALL have port sram_rd_en  output  1: SRAM read strobe.
REQ-014 SHALL have port sram_rd_addr  output  addr_width: SRAM read address.
REQ-015 SHALL have port sram_rd_data  input  arbiter_data_width: read data, valid in the cycle after sram_rd_en.
REQ-016 SHALL have port ready  input  num_of_ports: per-port downstream ready.
REQ-017 SHALL have port vld, sop, eop  output  num_of_ports each: one-hot on the active port, otherwise all zero.
REQ-018 SHALL have port data_out  output  arbiter_data_width: shared output data bus.
REQ-019 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-020 SHALL have port done  output  1: one-cycle pulse after the eop word is accepted.

Function
REQ-021 SHALL implement the FSM IDLE -> STREAM (on accept, length>0) -> DRAIN (last read issued) -> IDLE (eop word accepted).
REQ-022 SHALL, on an accept with length 0, issue no read and no vld, pulse done in the next cycle, and remain in IDLE.
REQ-023 SHALL latch des_port, length and start_addr on accept and ignore descriptor inputs until the block returns to IDLE.
REQ-024 SHALL issue exactly length reads, at start_addr, start_addr+1, ..., wrapping modulo 2^addr_width.
REQ-025 SHALL capture sram_rd_data into a 2-entry buffer in the cycle after each sram_rd_en.
REQ-026 SHALL assert sram_rd_en only while (buffered + in-flight - pop_this_cycle) < 2, so the buffer never overflows.
REQ-027 SHALL transfer a word when vld[p] && ready[p]; while ready[p] is low, data_out, vld, sop and eop SHALL hold stable.
REQ-028 SHALL raise vld[p] whenever the buffer is non-empty and drive data_out from the buffer head.
REQ-029 SHALL assert sop[p] with word 0 only, eop[p] with word length-1 only, and both together when length=1.
REQ-030 SHALL, with first-word latency, assert the first sram_rd_en in cycle T+1 and vld in cycle T+3 for an accept in cycle T.
REQ-031 SHALL sustain 1 word/cycle while ready[p] is held high.
REQ-032 SHALL pulse done in the cycle after the eop transfer, with IDLE and desc_ready=1 in that same cycle; back-to-back packets SHALL be allowed.

Reset
REQ-033 SHALL, on rst, force IDLE, clear the buffer, and discard the in-flight read.
REQ-034 SHALL, on rst, drive all outputs to 0 except desc_ready, which SHALL be 1 from the first cycle after rst deasserts.
REQ-035 SHALL, on rst mid-packet, abort the packet with no eop, no done, and no further reads.

Structure
REQ-036 SHALL take the width parameters and the FSM state encoding (IDLE=0, STREAM=1, DRAIN=2) from the shared sram_ctl package/header used by the write path.
REQ-037 SHALL implement the 2-entry buffer as sub-module rd_skid_buf (push, pop, data, count, full, empty).

Verification
REQ-038 SHALL check: port 5, length 4, addr 0x0100, ready all 1 -> reads 0x0100..0x0103 in cycles T+1..T+4; vld[5] in T+3..T+6; sop in T+3; eop in T+6; done in T+7.
REQ-039 SHALL check: length 1, port 0 -> vld[0], sop[0] and eop[0] all high in the same cycle; one read; done one cycle later.
REQ-040 SHALL check: port 9, length 8, ready[9] toggling 1/0 each cycle -> 8 ordered words, none lost or duplicated, and at most 2 reads outstanding beyond consumption.
REQ-041 SHALL check: addr 0x3FFE, length 4 -> reads 0x3FFE, 0x3FFF, 0x0000, 0x0001.
REQ-042 SHALL check: rst asserted at word 3 of a 10-word packet -> outputs 0 next cycle, no eop or done, desc_ready=1 after release.
REQ-043 SHALL check: two descriptors back-to-back (length 2, ports 1 then 2) and one length-0 descriptor -> no bubble beyond the 3-cycle latency, and done pulses for all three.

Source files
------------

// File: rtl/sram_ctl_pkg.sv
// Shared SRAM controller definitions: default widths and read-path FSM encoding.
package sram_ctl_pkg;

  localparam int unsigned NUM_OF_PORTS       = 16;
  localparam int unsigned ARBITER_DATA_WIDTH = 64;
  localparam int unsigned DES_PORT_WIDTH     = 4;
  localparam int unsigned PACK_LENGTH_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH         = 14;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry FIFO holding SRAM read data; head is always presented on data.
module rd_skid_buf #(
  parameter int unsigned width = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] data,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic [1:0]       cnt;
  logic             pop_ok;

  assign pop_ok = pop && (cnt != 2'd0);
  assign data   = head;
  assign count  = cnt;
  assign full   = (cnt == 2'd2);
  assign empty  = (cnt == 2'd0);

  // Shift-style storage: a pop moves tail into head, a push fills the first free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (cnt == 2'd0) begin
            head <= wdata;
            cnt  <= 2'd1;
          end else if (cnt == 2'd1) begin
            tail <= wdata;
            cnt  <= 2'd2;
          end
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= wdata;
          end else begin
            head <= tail;
            tail <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/read_dispatcher.sv
// Reads a packet from SRAM by descriptor and streams it to one output port.
module read_dispatcher
  import sram_ctl_pkg::*;
#(
  parameter int unsigned num_of_ports       = NUM_OF_PORTS,
  parameter int unsigned arbiter_data_width = ARBITER_DATA_WIDTH,
  parameter int unsigned des_port_width     = DES_PORT_WIDTH,
  parameter int unsigned pack_length_width  = PACK_LENGTH_WIDTH,
  parameter int unsigned addr_width         = ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          desc_vld,
  input  logic [des_port_width-1:0]     desc_des_port,
  input  logic [pack_length_width-1:0]  desc_pack_length,
  input  logic [addr_width-1:0]         desc_start_addr,
  output logic                          desc_ready,
  output logic                          sram_rd_en,
  output logic [addr_width-1:0]         sram_rd_addr,
  input  logic [arbiter_data_width-1:0] sram_rd_data,
  input  logic [num_of_ports-1:0]       ready,
  output logic [num_of_ports-1:0]       vld,
  output logic [num_of_ports-1:0]       sop,
  output logic [num_of_ports-1:0]       eop,
  output logic [arbiter_data_width-1:0] data_out,
  output logic                          busy,
  output logic                          done
);

  rd_state_e                     state;
  logic [des_port_width-1:0]     port_q;
  logic [pack_length_width-1:0]  len_q;
  logic [pack_length_width-1:0]  rd_cnt;
  logic [pack_length_width-1:0]  out_idx;
  logic [addr_width-1:0]         rd_addr;
  logic                          rd_pend;
  logic                          done_q;

  logic [pack_length_width-1:0]  last_idx;
  logic [arbiter_data_width-1:0] buf_data;
  logic [1:0]                    buf_count;
  logic                          buf_full;
  logic                          buf_empty;
  logic                          pop_c;
  logic                          at_cap_c;
  logic                          rd_issue_c;

  assign last_idx = len_q - pack_length_width'(1);
  assign pop_c    = !buf_empty && ready[port_q];

  // Buffered plus in-flight words already fill both slots; a pop this cycle frees one.
  assign at_cap_c   = buf_full || ((buf_count == 2'd1) && rd_pend);
  assign rd_issue_c = (state == STREAM) && (!at_cap_c || pop_c) && !rst;

  assign sram_rd_en   = rd_issue_c;
  assign sram_rd_addr = rd_addr;
  assign data_out     = buf_data;
  assign desc_ready   = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = done_q;

  rd_skid_buf #(
    .width (arbiter_data_width)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_pend),
    .pop   (pop_c),
    .wdata (sram_rd_data),
    .data  (buf_data),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  // Port strobes: one-hot on the latched port whenever the buffer head is valid.
  always_comb begin
    vld = '0;
    sop = '0;
    eop = '0;
    if (!buf_empty) begin
      vld[port_q] = 1'b1;
      sop[port_q] = (out_idx == '0);
      eop[port_q] = (out_idx == last_idx);
    end
  end

  // Control FSM with descriptor latch, read address/count and output word index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      port_q  <= '0;
      len_q   <= '0;
      rd_cnt  <= '0;
      out_idx <= '0;
      rd_addr <= '0;
      rd_pend <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      rd_pend <= rd_issue_c;
      done_q  <= 1'b0;
      if (rd_issue_c) begin
        rd_addr <= rd_addr + addr_width'(1);
        rd_cnt  <= rd_cnt + pack_length_width'(1);
      end
      if (pop_c) begin
        out_idx <= out_idx + pack_length_width'(1);
      end
      case (state)
        IDLE: begin
          if (desc_vld) begin
            port_q  <= desc_des_port;
            len_q   <= desc_pack_length;
            rd_addr <= desc_start_addr;
            rd_cnt  <= '0;
            out_idx <= '0;
            if (desc_pack_length == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (rd_issue_c && (rd_cnt == last_idx)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop_c && (out_idx == last_idx)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_dispatcher.sv
// Directed bench for read_dispatcher with a one-cycle-latency SRAM model.
module tb_read_dispatcher;

  localparam int unsigned NP = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned PW = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned AW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_vld;
  logic [PW-1:0] desc_des_port;
  logic [LW-1:0] desc_pack_length;
  logic [AW-1:0] desc_start_addr;
  logic          desc_ready;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_data = '0;
  logic [NP-1:0] ready;
  logic [NP-1:0] vld;
  logic [NP-1:0] sop;
  logic [NP-1:0] eop;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  read_dispatcher #(
    .num_of_ports       (NP),
    .arbiter_data_width (DW),
    .des_port_width     (PW),
    .pack_length_width  (LW),
    .addr_width         (AW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .desc_vld         (desc_vld),
    .desc_des_port    (desc_des_port),
    .desc_pack_length (desc_pack_length),
    .desc_start_addr  (desc_start_addr),
    .desc_ready       (desc_ready),
    .sram_rd_en       (sram_rd_en),
    .sram_rd_addr     (sram_rd_addr),
    .sram_rd_data     (sram_rd_data),
    .ready            (ready),
    .vld              (vld),
    .sop              (sop),
    .eop              (eop),
    .data_out         (data_out),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 64'hC0DE_0000_0000_0000 | DW'(a);
  endfunction

  // SRAM: data for the address read in one cycle appears in the next.
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem_word(sram_rd_addr);
  end

  task automatic drive_desc(input int port, input int len, input int addr);
    desc_vld         = 1'b1;
    desc_des_port    = PW'(port);
    desc_pack_length = LW'(len);
    desc_start_addr  = AW'(addr);
  endtask

  task automatic test_reset;
    rst = 1'b1; desc_vld = 1'b0; ready = '0;
    desc_des_port = '0; desc_pack_length = '0; desc_start_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++; if (sram_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", sram_rd_en); else pass_cnt++;
    total_cnt++; if (sram_rd_addr !== '0) $display("FAIL reset_rd_addr got %h want 0", sram_rd_addr); else pass_cnt++;
    total_cnt++; if ({vld, sop, eop} !== '0) $display("FAIL reset_strobes got %h want 0", {vld, sop, eop}); else pass_cnt++;
    total_cnt++; if (data_out !== '0) $display("FAIL reset_data got %h want 0", data_out); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b00) $display("FAIL reset_busy_done got %b want 00", {busy, done}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++; if (desc_ready !== 1'b1) $display("FAIL reset_desc_ready got %b want 1", desc_ready); else pass_cnt++;
  endtask

  task automatic test_basic;
    logic [31:0]   rd_m = '0, vld_m = '0, sop_m = '0, eop_m = '0, done_m = '0, busy_m = '0;
    logic [AW-1:0] adr_q[$];
    logic [DW-1:0] wrd_q[$];
    logic [NP-1:0] sop_v = '0, eop_v = '0;
    int            bad_port = 0;
    ready = '1;
    @(negedge clk);
    drive_desc(5, 4, 'h100);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      desc_vld = 1'b0;
      #1;
      if (sram_rd_en) begin rd_m[k] = 1'b1; adr_q.push_back(sram_rd_addr); end
      if (vld != '0) begin
        vld_m[k] = 1'b1; wrd_q.push_back(data_out);
        if (vld !== 16'h0020) bad_port++;
      end
      if (sop != '0) begin sop_m[k] = 1'b1; sop_v = sop; end
      if (eop != '0) begin eop_m[k] = 1'b1; eop_v = eop; end
      if (done) done_m[k] = 1'b1;
      if (busy) busy_m[k] = 1'b1;
    end
    total_cnt++; if (rd_m !== 32'h1E) $display("FAIL basic_rd_cycles got %h want 1e", rd_m); else pass_cnt++;
    total_cnt++; if (vld_m !== 32'h78) $display("FAIL basic_vld_cycles got %h want 78", vld_m); else pass_cnt++;
    total_cnt++; if (bad_port !== 0) $display("FAIL basic_vld_port got %0d bad want 0", bad_port); else pass_cnt++;
    total_cnt++; if (sop_m !== 32'h8 || sop_v !== 16'h0020) $display("FAIL basic_sop got %h/%h want 8/0020", sop_m, sop_v); else pass_cnt++;
    total_cnt++; if (eop_m !== 32'h40 || eop_v !== 16'h0020) $display("FAIL basic_eop got %h/%h want 40/0020", eop_m, eop_v); else pass_cnt++;
    total_cnt++; if (done_m !== 32'h80) $display("FAIL basic_done got %h want 80", done_m); else pass_cnt++;
    total_cnt++; if (busy_m !== 32'h7E) $display("FAIL basic_busy got %h want 7e", busy_m); else pass_cnt++;
    total_cnt++;
    if (adr_q.size() != 4 || wrd_q.size() != 4) $display("FAIL basic_count got %0d/%0d want 4/4", adr_q.size(), wrd_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < adr_q.size() && i < wrd_q.size(); i++) begin
      total_cnt++; if (adr_q[i] !== AW'('h100 + i)) $display("FAIL basic_addr%0d got %h want %h", i, adr_q[i], AW'('h100 + i)); else pass_cnt++;
      total_cnt++; if (wrd_q[i] !== mem_word(AW'('h100 + i))) $display("FAIL basic_word%0d got %h want %h", i, wrd_q[i], mem_word(AW'('h100 + i))); else pass_cnt++;
    end
  endtask

  task automatic test_single;
    logic [31:0]   rd_m = '0, vld_m = '0, done_m = '0;
    logic [3*NP-1:0] bus3 = '0;
    logic [AW-1:0] adr = '1;
    logic [DW-1:0] wrd = '0;
    ready = '1;
    @(negedge clk);
    drive_desc(0, 1, 'h020);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      desc_vld = 1'b0;
      #1;
      if (sram_rd_en) begin rd_m[k] = 1'b1; adr = sram_rd_addr; end
      if (vld != '0) begin vld_m[k] = 1'b1; bus3 = {vld, sop, eop}; wrd = data_out; end
      if (done) done_m[k] = 1'b1;
    end
    total_cnt++; if (rd_m !== 32'h2 || adr !== AW'('h020)) $display("FAIL single_read got %h@%h want 2@020", rd_m, adr); else pass_cnt++;
    total_cnt++; if (vld_m !== 32'h8) $display("FAIL single_vld_cycles got %h want 8", vld_m); else pass_cnt++;
    total_cnt++; if (bus3 !== {16'h1, 16'h1, 16'h1}) $display("FAIL single_vld_sop_eop got %h want 000100010001", bus3); else pass_cnt++;
    total_cnt++; if (wrd !== mem_word(AW'('h020))) $display("FAIL single_word got %h want %h", wrd, mem_word(AW'('h020))); else pass_cnt++;
    total_cnt++; if (done_m !== 32'h10) $display("FAIL single_done got %h want 10", done_m); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    logic [DW-1:0]      wrd_q[$];
    int                 sop_at[$], eop_at[$];
    int                 issued = 0, popped = 0, max_out = 0, hold_err = 0, stray = 0;
    logic               prev_stall = 1'b0, done_seen = 1'b0, p;
    logic [3*NP+DW-1:0] prev_bus = '0;
    ready = '0;
    @(negedge clk);
    drive_desc(9, 8, 'h200);
    for (int k = 1; k <= 60 && !done_seen; k++) begin
      @(negedge clk);
      desc_vld = 1'b0;
      ready = (k % 2 == 1) ? 16'h0200 : 16'h0000;
      #1;
      if (sram_rd_en) issued++;
      if ((vld & ~16'h0200) != '0) stray++;
      if (prev_stall && ({vld, sop, eop, data_out} !== prev_bus)) hold_err++;
      prev_stall = vld[9] && !ready[9];
      prev_bus   = {vld, sop, eop, data_out};
      p = vld[9] && ready[9];
      if (p) begin
        if (sop[9]) sop_at.push_back(wrd_q.size());
        if (eop[9]) eop_at.push_back(wrd_q.size());
        wrd_q.push_back(data_out);
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) done_seen = 1'b1;
    end
    total_cnt++; if (done_seen !== 1'b1) $display("FAIL bp_done_timeout got %b want 1", done_seen); else pass_cnt++;
    total_cnt++; if (issued !== 8) $display("FAIL bp_reads got %0d want 8", issued); else pass_cnt++;
    total_cnt++; if (wrd_q.size() !== 8) $display("FAIL bp_words got %0d want 8", wrd_q.size()); else pass_cnt++;
    for (int i = 0; i < 8 && i < wrd_q.size(); i++) begin
      total_cnt++; if (wrd_q[i] !== mem_word(AW'('h200 + i))) $display("FAIL bp_word%0d got %h want %h", i, wrd_q[i], mem_word(AW'('h200 + i))); else pass_cnt++;
    end
    total_cnt++; if (max_out > 2) $display("FAIL bp_outstanding got %0d want <=2", max_out); else pass_cnt++;
    total_cnt++; if (hold_err !== 0) $display("FAIL bp_hold got %0d changes want 0", hold_err); else pass_cnt++;
    total_cnt++; if (stray !== 0) $display("FAIL bp_stray_port got %0d want 0", stray); else pass_cnt++;
    total_cnt++; if (sop_at.size() != 1 || sop_at[0] !== 0) $display("FAIL bp_sop got %0d entries want 1 at word 0", sop_at.size()); else pass_cnt++;
    total_cnt++; if (eop_at.size() != 1 || eop_at[0] !== 7) $display("FAIL bp_eop got %0d entries want 1 at word 7", eop_at.size()); else pass_cnt++;
  endtask

  task automatic test_wrap;
    logic [AW-1:0] adr_q[$];
    logic [DW-1:0] wrd_q[$];
    logic [AW-1:0] exp_a[4];
    logic [31:0]   done_m = '0;
    exp_a[0] = 14'h3FFE; exp_a[1] = 14'h3FFF; exp_a[2] = 14'h0000; exp_a[3] = 14'h0001;
    ready = '1;
    @(negedge clk);
    drive_desc(3, 4, 'h3FFE);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      desc_vld = 1'b0;
      #1;
      if (sram_rd_en) adr_q.push_back(sram_rd_addr);
      if (vld[3]) wrd_q.push_back(data_out);
      if (done) done_m[k] = 1'b1;
    end
    total_cnt++;
    if (adr_q.size() != 4 || wrd_q.size() != 4) $display("FAIL wrap_count got %0d/%0d want 4/4", adr_q.size(), wrd_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < adr_q.size() && i < wrd_q.size(); i++) begin
      total_cnt++; if (adr_q[i] !== exp_a[i]) $display("FAIL wrap_addr%0d got %h want %h", i, adr_q[i], exp_a[i]); else pass_cnt++;
      total_cnt++; if (wrd_q[i] !== mem_word(exp_a[i])) $display("FAIL wrap_word%0d got %h want %h", i, wrd_q[i], mem_word(exp_a[i])); else pass_cnt++;
    end
    total_cnt++; if (done_m !== 32'h80) $display("FAIL wrap_done got %h want 80", done_m); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int   pops = 0, late = 0;
    logic hit = 1'b0;
    ready = '1;
    @(negedge clk);
    drive_desc(7, 10, 'h050);
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(negedge clk);
      desc_vld = 1'b0;
      #1;
      if (vld[7]) begin
        if (pops == 3) begin rst = 1'b1; hit = 1'b1; end
        pops++;
      end
    end
    total_cnt++; if (hit !== 1'b1) $display("FAIL rstmid_reach_word3 got %b want 1", hit); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++; if ({vld, sop, eop} !== '0) $display("FAIL rstmid_strobes got %h want 0", {vld, sop, eop}); else pass_cnt++;
    total_cnt++; if (data_out !== '0) $display("FAIL rstmid_data got %h want 0", data_out); else pass_cnt++;
    total_cnt++; if ({sram_rd_en, busy, done} !== 3'b000) $display("FAIL rstmid_ctl got %b want 000", {sram_rd_en, busy, done}); else pass_cnt++;
    @(negedge clk);
    #1;
    total_cnt++; if (desc_ready !== 1'b1) $display("FAIL rstmid_desc_ready got %b want 1", desc_ready); else pass_cnt++;
    for (int k = 0; k < 15; k++) begin
      if (eop != '0 || done || sram_rd_en || vld != '0) late++;
      @(negedge clk);
      #1;
    end
    total_cnt++; if (late !== 0) $display("FAIL rstmid_activity got %0d cycles want 0", late); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int            ports[3], lens[3], addrs[3];
    int            idx = 0;
    logic [31:0]   acc_m = '0, done_m = '0, rd_m = '0, vld_m = '0, sop_m = '0;
    logic [NP-1:0] sop_v[32];
    ports = '{1, 2, 0}; lens = '{2, 2, 0}; addrs = '{'h400, 'h410, 'h420};
    foreach (sop_v[i]) sop_v[i] = '0;
    ready = '1;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (sram_rd_en) rd_m[k] = 1'b1;
      if (vld != '0) vld_m[k] = 1'b1;
      if (sop != '0) begin sop_m[k] = 1'b1; sop_v[k] = sop; end
      if (done) done_m[k] = 1'b1;
      if (desc_ready && idx < 3) begin
        drive_desc(ports[idx], lens[idx], addrs[idx]);
        acc_m[k] = 1'b1;
        idx++;
      end else begin
        desc_vld = 1'b0;
      end
    end
    desc_vld = 1'b0;
    total_cnt++; if (acc_m !== 32'h421) $display("FAIL b2b_accepts got %h want 421", acc_m); else pass_cnt++;
    total_cnt++; if (rd_m !== 32'hC6) $display("FAIL b2b_reads got %h want c6", rd_m); else pass_cnt++;
    total_cnt++; if (vld_m !== 32'h318) $display("FAIL b2b_vld got %h want 318", vld_m); else pass_cnt++;
    total_cnt++; if (sop_m !== 32'h108) $display("FAIL b2b_sop_cycles got %h want 108", sop_m); else pass_cnt++;
    total_cnt++; if (sop_v[3] !== 16'h0002 || sop_v[8] !== 16'h0004) $display("FAIL b2b_sop_ports got %h/%h want 0002/0004", sop_v[3], sop_v[8]); else pass_cnt++;
    total_cnt++; if (done_m !== 32'hC20) $display("FAIL b2b_done got %h want c20", done_m); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
